bk_spi_master: RTL and testbench
================================

Name: bk_spi_master

Overview:
- Byte-wide SPI master that sits directly downstream of the core's USRREG (0177714) port.
- Consumes the core's spi_wren / spi_do / spi_cs_n outputs and returns spi_di / spi_dsr for register readback.
- Drives the external SD-card/flash pins (SCK, MOSI, CS_n) and samples MISO.
- Fixed SPI mode 0, MSB first, 8-bit frames.

Parameters:
- DIV, 4: SCK half-period in clk cycles. Legal range 1..255.
- Counter width is $clog2(DIV+1).

Ports:
- clk  in  1  core clock, the same clk as the core.
- reset  in  1  asynchronous, active-high reset.
- wren  in  1  write strobe from the core. May stay high for several clk cycles, one full ce period.
- din  in  8  byte to transmit (core spi_do).
- cs_n_i  in  1  chip-select request from the core (core spi_cs_n).
- dsr  out  1  1 = idle/ready, 0 = transfer in progress. Feeds the core spi_dsr.
- dout  out  8  last received byte. Feeds the core spi_di.
- sck  out  1  SPI clock. Idle level 0.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in. Synchronised through 2 flops.
- cs_n_o  out  1  registered chip select to the device.

Behaviour:
Reset (asynchronous, any state):
- state=IDLE, dsr=1, dout=8'hFF, sck=0, mosi=1, cs_n_o=1, bit counter=0, divider=0, wren_d=0.

Start detection:
- wren_d is wren registered every clk.
- start = wren & ~wren_d & (state==IDLE).
- A wren held high, however long, yields exactly one transfer.
- A rising edge of wren while not IDLE is ignored. No queueing. The byte is dropped.

cs_n_o:
- cs_n_o <= cs_n_i every clk (1-cycle delay).

States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - On start: tx_sr <= din; mosi <= din[7]; dsr <= 0; divider <= 0; bitcnt <= 0; go to LOW.
- LOW:
  - sck=0.
  - When divider==DIV-1: divider <= 0; sck <= 1; rx_sr <= {rx_sr[6:0], miso_sync}; go to HIGH.
  - Otherwise divider++.
- HIGH:
  - sck=1.
  - When divider==DIV-1: divider <= 0; sck <= 0.
    - If bitcnt==7: go to DONE.
    - Otherwise: bitcnt++; tx_sr shifts left; mosi <= next bit (tx_sr[6]); go to LOW.
  - Otherwise divider++.
- DONE:
  - dout <= rx_sr; dsr <= 1; mosi <= 1; go to IDLE.

Timing:
- MISO is sampled on the rising SCK edge. MOSI changes on the falling SCK edge.
- MOSI bit7 is valid DIV clk before the first rising edge.
- Exactly 8 SCK pulses per transfer.
- dsr is 0 from the clk after the start edge through DONE.
- dsr returns to 1 exactly 16*DIV+1 clk after the start cycle.
- dout updates in the same cycle that dsr rises.
- A start is accepted on the first clk in IDLE after DONE.

Abort:
- cs_n_i==1 while state is LOW or HIGH forces, next clk: state=IDLE, sck=0, mosi=1, dsr=1.
- dout is unchanged on abort.
- cs_n_i is not required for start. A transfer may run with cs_n_i=1 only if cs_n_i stays 1 from the start. Precise rule: abort triggers only on a 0->1 transition of cs_n_i during LOW/HIGH.

Reset mid-transfer:
- Immediate return to reset values. No partial dout update.

Miscellaneous:
- ce is not used; the divider counts raw clk.
- All outputs are registered.

Decomposition:
- Shared include spi_defs.vh holds:
  - the state encodings (2-bit: IDLE=0, LOW=1, HIGH=2, DONE=3);
  - the reset constant DOUT_RST=8'hFF;
  - MODE0 / MSB_FIRST documentation constants for future master variants.
- No sub-module. The 2-flop MISO synchroniser is inline. The divider/phase logic is small enough to stay in one always block.

Test Plan:
- Reset check: assert reset mid-idle and at random points -> dsr=1, dout=FF, sck=0, mosi=1, cs_n_o=1 within the same cycle (async).
- Loopback, DIV=4: miso tied to mosi; cs_n_i=0; pulse wren with din=A5 -> 8 sck pulses, each high 4 clk; mosi bit sequence 1,0,1,0,0,1,0,1; dsr=0 for 65 clk; then dout=A5, dsr=1.
- Slave pattern: DIV=1; din=00; miso driven per rising edge with 3C -> dout=3C; dsr low for 17 clk.
- Held strobe: wren high for 40 clk with din=81, then a second edge 10 clk after dsr rises -> exactly two transfers; the second transfer's byte is taken at its own edge.
- Busy drop: new wren edge at clk 20 of a transfer with din=FF -> ignored; transfer completes with the original byte; no second transfer starts.
- Abort: cs_n_i 0->1 after the 3rd SCK rising edge -> next clk sck=0, dsr=1, dout keeps its prior value; a subsequent start transfers a full 8 bits correctly.

Source files
------------

// File: rtl/bk_spi_master_pkg.sv
// ---------------------------------------------------------------------------
// bk_spi_master_pkg
// Shared definitions for the byte-wide SPI master and future master variants.
//   spi_state_t  : 2-bit transfer state encoding (IDLE=0, LOW=1, HIGH=2, DONE=3)
//   DOUT_RST     : value of the receive-byte register out of reset
//   MODE0        : documents the fixed clock mode (CPOL=0, CPHA=0)
//   MSB_FIRST    : documents the fixed bit order
// ---------------------------------------------------------------------------
package bk_spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

  localparam logic [7:0] DOUT_RST  = 8'hFF;
  localparam bit         MODE0     = 1'b1;
  localparam bit         MSB_FIRST = 1'b1;

endpackage

// File: rtl/bk_spi_master.sv
// ---------------------------------------------------------------------------
// bk_spi_master
// Byte-wide SPI master (mode 0, MSB first) behind the core's USRREG port.
// Ports:
//   clk     in   core clock
//   reset   in   asynchronous active-high reset
//   wren    in   write strobe from the core; a rising edge in IDLE starts a byte
//   din     in   byte to transmit
//   cs_n_i  in   chip-select request from the core
//   dsr     out  1 = idle/ready, 0 = transfer in progress
//   dout    out  last received byte
//   sck     out  SPI clock, idle low
//   mosi    out  SPI data out, idles high
//   miso    in   SPI data in (two-flop synchronised)
//   cs_n_o  out  chip select to the device, cs_n_i delayed one clk
// Parameter DIV sets the SCK half-period in clk cycles (1..255).
// ---------------------------------------------------------------------------
module bk_spi_master
  import bk_spi_master_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic [7:0] din,
  input  logic       cs_n_i,
  output logic       dsr,
  output logic [7:0] dout,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n_o
);

  localparam int             CW       = $clog2(DIV + 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

  spi_state_t    state_reg, state_next;
  logic [CW-1:0] div_reg, div_next;
  logic [2:0]    bitcnt_reg, bitcnt_next;
  // din[7] goes straight to mosi, so only the remaining seven bits are kept.
  logic [6:0]    tx_sr_reg, tx_sr_next;
  logic [7:0]    rx_sr_reg, rx_sr_next;
  logic [7:0]    dout_reg, dout_next;
  logic          dsr_reg, dsr_next;
  logic          sck_reg, sck_next;
  logic          mosi_reg, mosi_next;
  logic          wren_d_reg;
  logic          cs_n_o_reg;
  logic          miso_s1_reg, miso_s2_reg;

  logic start;
  logic abort;

  // Edge-detect so that a strobe held for many cycles starts only one byte.
  assign start = wren & ~wren_d_reg & (state_reg == ST_IDLE);
  // Only a fresh deassertion aborts; a transfer begun with cs_n_i already
  // high runs to completion.
  assign abort = cs_n_i & ~cs_n_o_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    bitcnt_next = bitcnt_reg;
    tx_sr_next  = tx_sr_reg;
    rx_sr_next  = rx_sr_reg;
    dout_next   = dout_reg;
    dsr_next    = dsr_reg;
    sck_next    = sck_reg;
    mosi_next   = mosi_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          tx_sr_next  = din[6:0];
          mosi_next   = din[7];
          dsr_next    = 1'b0;
          div_next    = '0;
          bitcnt_next = '0;
          state_next  = ST_LOW;
        end
      end

      ST_LOW, ST_HIGH: begin
        if (abort) begin
          state_next = ST_IDLE;
          sck_next   = 1'b0;
          mosi_next  = 1'b1;
          dsr_next   = 1'b1;
          div_next   = '0;
        end else if (div_reg != DIV_LAST) begin
          div_next = div_reg + CW'(1);
        end else if (state_reg == ST_LOW) begin
          // Rising SCK: capture MISO.
          div_next   = '0;
          sck_next   = 1'b1;
          rx_sr_next = {rx_sr_reg[6:0], miso_s2_reg};
          state_next = ST_HIGH;
        end else begin
          // Falling SCK: present the next MOSI bit or finish.
          div_next = '0;
          sck_next = 1'b0;
          if (bitcnt_reg == 3'd7) begin
            state_next = ST_DONE;
          end else begin
            bitcnt_next = bitcnt_reg + 3'd1;
            mosi_next   = tx_sr_reg[6];
            tx_sr_next  = {tx_sr_reg[5:0], 1'b0};
            state_next  = ST_LOW;
          end
        end
      end

      ST_DONE: begin
        dout_next  = rx_sr_reg;
        dsr_next   = 1'b1;
        mosi_next  = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg     <= '0;
      bitcnt_reg  <= '0;
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      dout_reg    <= DOUT_RST;
      dsr_reg     <= 1'b1;
      sck_reg     <= 1'b0;
      mosi_reg    <= 1'b1;
      wren_d_reg  <= 1'b0;
      cs_n_o_reg  <= 1'b1;
      miso_s1_reg <= 1'b1;
      miso_s2_reg <= 1'b1;
    end else begin
      div_reg     <= div_next;
      bitcnt_reg  <= bitcnt_next;
      tx_sr_reg   <= tx_sr_next;
      rx_sr_reg   <= rx_sr_next;
      dout_reg    <= dout_next;
      dsr_reg     <= dsr_next;
      sck_reg     <= sck_next;
      mosi_reg    <= mosi_next;
      wren_d_reg  <= wren;
      cs_n_o_reg  <= cs_n_i;
      miso_s1_reg <= miso;
      miso_s2_reg <= miso_s1_reg;
    end
  end

  assign dsr    = dsr_reg;
  assign dout   = dout_reg;
  assign sck    = sck_reg;
  assign mosi   = mosi_reg;
  assign cs_n_o = cs_n_o_reg;

endmodule

// File: tb/tb_bk_spi_master.sv
// ---------------------------------------------------------------------------
// tb_bk_spi_master
// Directed bench for bk_spi_master: a DIV=4 instance in loopback (miso=mosi)
// and a DIV=1 instance fed a fixed slave pattern. Expected received bytes go
// into a queue when a transfer is launched and are popped when dsr returns.
// ---------------------------------------------------------------------------
module tb_bk_spi_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // DIV=4 instance, loopback by default
  logic       wren4 = 1'b0;
  logic [7:0] din4  = 8'h00;
  logic       cs4   = 1'b0;
  logic       dsr4, sck4, mosi4, cs_o4, miso4;
  logic [7:0] dout4;

  // DIV=1 instance, bench-driven miso
  logic       wren1 = 1'b0;
  logic [7:0] din1  = 8'h00;
  logic       cs1   = 1'b0;
  logic       miso1 = 1'b1;
  logic       dsr1, sck1, mosi1, cs_o1;
  logic [7:0] dout1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_dout = 8'hFF;

  assign miso4 = mosi4;

  always #5 clk = ~clk;

  bk_spi_master #(.DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .wren(wren4), .din(din4), .cs_n_i(cs4),
    .dsr(dsr4), .dout(dout4), .sck(sck4), .mosi(mosi4), .miso(miso4),
    .cs_n_o(cs_o4)
  );

  bk_spi_master #(.DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .wren(wren1), .din(din1), .cs_n_i(cs1),
    .dsr(dsr1), .dout(dout1), .sck(sck1), .mosi(mosi1), .miso(miso1),
    .cs_n_o(cs_o1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on the DIV=4 instance. hold: cycles wren stays high;
  // inject_at: cycle of a second wren pulse (din=FF) while busy, 0 = none;
  // abort_rise: raise cs_n_i after this SCK rising edge, 0 = no abort;
  // exp_low: expected number of clk with dsr low.
  task automatic xfer4(input string tag, input logic [7:0] d, input int hold,
                       input int inject_at, input int abort_rise, input int exp_low);
    int cyc, done_cyc, low_cnt, rises, high_cnt;
    logic [7:0] mosi_bits, dout_at_done, exp_dout;
    logic prev_sck, sck_at_done, mosi_at_done;
    bit idle_ok;
    cyc = 0; done_cyc = 0; low_cnt = 0; rises = 0; high_cnt = 0;
    mosi_bits = 8'h00; dout_at_done = 8'h00; prev_sck = 1'b0;
    sck_at_done = 1'b0; mosi_at_done = 1'b0; idle_ok = 1'b1;

    @(negedge clk);
    din4  = d;
    wren4 = 1'b1;
    exp_q.push_back((abort_rise > 0) ? model_dout : d);

    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) wren4 = 1'b0;
      if (inject_at > 0 && cyc == inject_at) begin
        wren4 = 1'b1;
        din4  = 8'hFF;
      end
      if (inject_at > 0 && cyc == inject_at + 1) wren4 = 1'b0;
      if (done_cyc == 0) begin
        if (dsr4 === 1'b1) begin
          done_cyc     = cyc;
          dout_at_done = dout4;
          sck_at_done  = sck4;
          mosi_at_done = mosi4;
        end else begin
          low_cnt++;
          if (sck4 === 1'b1) high_cnt++;
          if (sck4 === 1'b1 && prev_sck === 1'b0) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], mosi4};
            if (rises == abort_rise) cs4 = 1'b1;
          end
          prev_sck = sck4;
        end
      end else if (dsr4 !== 1'b1 || sck4 !== 1'b0) begin
        idle_ok = 1'b0;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 10 && cyc >= hold) break;
    end

    exp_dout = exp_q.pop_front();
    check({tag, "_dsr_low_len"}, low_cnt, exp_low);
    check({tag, "_dout"}, dout_at_done, exp_dout);
    if (abort_rise > 0) begin
      check({tag, "_abort_sck"}, sck_at_done, 1'b0);
      check({tag, "_abort_mosi"}, mosi_at_done, 1'b1);
      cs4 = 1'b0;
    end else begin
      check({tag, "_sck_pulses"}, rises, 8);
      check({tag, "_sck_high_clk"}, high_cnt, 32);
      check({tag, "_mosi_bits"}, mosi_bits, d);
      model_dout = d;
    end
    check({tag, "_stays_idle"}, idle_ok, 1'b1);
    $display("xfer %s din=%02h dout=%02h dsr_low=%0d sck_rises=%0d", tag, d, dout_at_done, low_cnt, rises);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int cyc, low_cnt, rises;
    logic prev_sck;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_dsr", dsr4, 1'b1);
    check("rst_dout", dout4, 8'hFF);
    check("rst_sck", sck4, 1'b0);
    check("rst_mosi", mosi4, 1'b1);
    check("rst_cs_n_o", cs_o4, 1'b1);
    check("rst_dout_div1", dout1, 8'hFF);
    $display("reset: dsr=%b dout=%02h sck=%b mosi=%b cs_n_o=%b", dsr4, dout4, sck4, mosi4, cs_o4);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("cs_n_o_follows", cs_o4, 1'b0);

    // ---------------- loopback A5 ----------------
    xfer4("loop_a5", 8'hA5, 1, 0, 0, 65);

    // ---------------- DIV=1 slave pattern 3C ----------------
    pat = 8'h3C;
    @(negedge clk);
    miso1 = pat[7];
    repeat (2) @(negedge clk);
    din1  = 8'h00;
    wren1 = 1'b1;
    exp_q.push_back(pat);
    cyc = 0; low_cnt = 0; rises = 0; prev_sck = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) wren1 = 1'b0;
      // Bit i is picked up by the first synchroniser flop two clk before
      // the rising edge that samples it.
      for (int i = 1; i < 8; i++) if (cyc == 2 * i - 1) miso1 = pat[7 - i];
      if (dsr1 === 1'b1) break;
      low_cnt++;
      if (sck1 === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck1;
    end
    check("slave_dsr_low_len", low_cnt, 17);
    check("slave_sck_pulses", rises, 8);
    check("slave_dout", dout1, exp_q.pop_front());
    $display("xfer slave din=00 dout=%02h dsr_low=%0d sck_rises=%0d", dout1, low_cnt, rises);

    // ---------------- held strobe, then a second edge ----------------
    // wren stays high past the end of the transfer: no retrigger.
    xfer4("held_81", 8'h81, 70, 0, 0, 65);
    xfer4("second_3c", 8'h3C, 1, 0, 0, 65);

    // ---------------- busy drop ----------------
    xfer4("busy_c3", 8'hC3, 1, 20, 0, 65);

    // ---------------- abort after 3rd rising edge ----------------
    xfer4("abort_5a", 8'h5A, 1, 0, 3, 21);
    repeat (3) @(negedge clk);
    xfer4("after_abort_69", 8'h69, 1, 0, 0, 65);

    // ---------------- asynchronous reset mid-transfer ----------------
    @(negedge clk);
    din4  = 8'h96;
    wren4 = 1'b1;
    @(negedge clk);
    wren4 = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy_dsr", dsr4, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_dsr", dsr4, 1'b1);
    check("mid_rst_dout", dout4, 8'hFF);
    check("mid_rst_sck", sck4, 1'b0);
    check("mid_rst_mosi", mosi4, 1'b1);
    check("mid_rst_cs_n_o", cs_o4, 1'b1);
    $display("async reset: dsr=%b dout=%02h sck=%b mosi=%b cs_n_o=%b", dsr4, dout4, sck4, mosi4, cs_o4);
    @(negedge clk);
    reset = 1'b0;
    model_dout = 8'hFF;
    repeat (3) @(negedge clk);

    xfer4("post_reset_e7", 8'hE7, 1, 0, 0, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
